// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_pkg: opcodes, formats and fetch-queue types                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package riscv_pkg;

  localparam int FQ_PC_W    = 32;
  localparam int FQ_ENTRY_W = 32 + FQ_PC_W;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fq_state_e;

  typedef struct packed {
    logic [31:0]        instr;
    logic [FQ_PC_W-1:0] pc;
  } fq_entry_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_sync_fifo: DEPTH-entry synchronous FIFO with occupancy     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module riscv_sync_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FQ_ENTRY_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push = i_push && !i_flush && (r_count != CNT_W'(DEPTH));
  assign w_pop  = i_pop  && !i_flush && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale words are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/riscv_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_fetch_queue: fetch-to-decode buffer with illegal-op trap   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fetch_valid_i,
  output logic             fetch_ready_o,
  input  logic [31:0]      fetch_instr_i,
  input  logic [PC_W-1:0]  fetch_pc_i,
  input  logic             flush_i,
  output logic [31:0]      chk_instr_o,
  input  logic             chk_valid_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [31:0]      dec_instr_o,
  output logic [PC_W-1:0]  dec_pc_o,
  output logic             illegal_o,
  output logic [31:0]      illegal_instr_o,
  output logic [PC_W-1:0]  illegal_pc_o,
  output logic [CNT_W-1:0] count_o
);

  fq_state_e              r_state;
  fq_state_e              w_state_next;
  fq_entry_t              w_wr_entry;
  fq_entry_t              w_head;
  logic [FQ_ENTRY_W-1:0]  w_rdata;
  logic [CNT_W-1:0]       w_count;
  logic                   w_has_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_trap;
  logic [31:0]            r_ill_instr;
  logic [PC_W-1:0]        r_ill_pc;

  assign w_wr_entry.instr = fetch_instr_i;
  assign w_wr_entry.pc    = FQ_PC_W'(fetch_pc_i);

  riscv_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FQ_ENTRY_W)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_flush (flush_i),
    .i_push  (w_push),
    .i_wdata (w_wr_entry),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  assign w_head     = w_rdata;
  assign w_has_head = (w_count != '0);

  // Ready depends only on registered state and flush, never on decode.
  assign fetch_ready_o = (r_state == RUN) && (w_count < CNT_W'(DEPTH)) && !flush_i;
  assign dec_valid_o   = (r_state == RUN) && w_has_head && chk_valid_i;
  assign w_push        = fetch_valid_i && fetch_ready_o;
  assign w_pop         = dec_valid_o && dec_ready_i && !flush_i;

  assign chk_instr_o = w_has_head ? w_head.instr : 32'h0;
  assign dec_instr_o = w_has_head ? w_head.instr : 32'h0;
  assign dec_pc_o    = w_has_head ? PC_W'(w_head.pc) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_trap       = 1'b0;
    case (r_state)
      RUN: begin
        // An empty queue shows 32'h0 to the validator; its verdict is ignored.
        if (!flush_i && w_has_head && !chk_valid_i) begin
          w_state_next = TRAP;
          w_trap       = 1'b1;
        end
      end
      TRAP: begin
        if (flush_i) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_ill_instr <= 32'h0;
      r_ill_pc    <= '0;
    end else if (w_trap) begin
      r_ill_instr <= w_head.instr;
      r_ill_pc    <= PC_W'(w_head.pc);
    end
  end

  assign illegal_o       = (r_state == TRAP);
  assign illegal_instr_o = r_ill_instr;
  assign illegal_pc_o    = r_ill_pc;
  assign count_o         = w_count;

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_riscv_fetch_queue: directed + random bench with queue model   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_riscv_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_instr_i = 32'h0;
  logic [31:0] fetch_pc_i = 32'h0;
  logic        flush_i = 1'b0;
  logic [31:0] chk_instr_o;
  logic        chk_valid_i;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic        illegal_o;
  logic [31:0] illegal_instr_o;
  logic [31:0] illegal_pc_o;
  logic [2:0]  count_o;
  logic        veto = 1'b0;

  ent_t        m_q[$];
  bit          m_trap = 1'b0;
  bit          m_known = 1'b0;
  logic [31:0] m_ill_i = 32'h0;
  logic [31:0] m_ill_p = 32'h0;
  logic [31:0] dec_log[$];
  int          n_vec = 0;
  int          n_err = 0;

  riscv_fetch_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_ready_o   (fetch_ready_o),
    .fetch_instr_i   (fetch_instr_i),
    .fetch_pc_i      (fetch_pc_i),
    .flush_i         (flush_i),
    .chk_instr_o     (chk_instr_o),
    .chk_valid_i     (chk_valid_i),
    .dec_valid_o     (dec_valid_o),
    .dec_ready_i     (dec_ready_i),
    .dec_instr_o     (dec_instr_o),
    .dec_pc_o        (dec_pc_o),
    .illegal_o       (illegal_o),
    .illegal_instr_o (illegal_instr_o),
    .illegal_pc_o    (illegal_pc_o),
    .count_o         (count_o)
  );

  always #5 clk = ~clk;

  // Stand-in legality checker: RV32I base opcodes only; veto forces a reject.
  function automatic logic is_legal(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  assign chk_valid_i = is_legal(chk_instr_o) && !veto;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 9) != 0) begin
      case ($urandom_range(0, 3))
        0:       w[6:0] = 7'h13;
        1:       w[6:0] = 7'h33;
        2:       w[6:0] = 7'h03;
        default: w[6:0] = 7'h63;
      endcase
    end
    return w;
  endfunction

  // One clock: drive on the falling edge, compare, then advance the model.
  task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic dr, input logic fl, input logic rs, input logic vt);
    bit hv, hl, e_ready, e_dv;
    @(negedge clk);
    fetch_valid_i = fv;
    fetch_instr_i = ins;
    fetch_pc_i    = pc;
    dec_ready_i   = dr;
    flush_i       = fl;
    rst_i         = rs;
    veto          = vt;
    #1;
    hv      = (m_q.size() > 0);
    hl      = hv && is_legal(m_q[0].instr) && !vt;
    e_ready = !m_trap && (m_q.size() < DEPTH) && !fl;
    e_dv    = !m_trap && hl;
    if (m_known) begin
      check("count", 32'(count_o), 32'(m_q.size()));
      check("fetch_ready", 32'(fetch_ready_o), 32'(e_ready));
      check("dec_valid", 32'(dec_valid_o), 32'(e_dv));
      check("illegal", 32'(illegal_o), 32'(m_trap));
      if (hv) begin
        check("chk_instr", chk_instr_o, m_q[0].instr);
        check("dec_instr", dec_instr_o, m_q[0].instr);
        check("dec_pc", dec_pc_o, m_q[0].pc);
      end else begin
        check("chk_instr_empty", chk_instr_o, 32'h0);
      end
      if (m_trap) begin
        check("illegal_instr", illegal_instr_o, m_ill_i);
        check("illegal_pc", illegal_pc_o, m_ill_p);
      end
    end
    if (dec_valid_o && dr) dec_log.push_back(dec_pc_o);
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_trap  = 1'b0;
      m_known = 1'b1;
    end else if (fl) begin
      m_q.delete();
      m_trap = 1'b0;
    end else begin
      if (!m_trap && hv && !hl) begin
        m_trap  = 1'b1;
        m_ill_i = m_q[0].instr;
        m_ill_p = m_q[0].pc;
      end
      if (e_dv && dr) void'(m_q.pop_front());
      if (fv && e_ready) m_q.push_back('{instr: ins, pc: pc});
    end
  endtask

  initial begin
    logic [31:0] pc;

    // Reset held two cycles while fetch offers a word.
    step(1'b1, 32'h00000013, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h00000013, 32'h84, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_dec_valid", 32'(dec_valid_o), 32'h0);
    check("rst_illegal", 32'(illegal_o), 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stream two legal words.
    dec_log.delete();
    step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h002081B3, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stream_n", 32'(dec_log.size()), 32'd2);
    for (int k = 0; k < 2; k++)
      check("stream_pc", (k < dec_log.size()) ? dec_log[k] : 32'hDEADDEAD, 32'h100 + 32'(4 * k));

    // Fill past capacity, then drain.
    dec_log.delete();
    for (int k = 0; k < 5; k++)
      step(1'b1, 32'h00000013 | (32'(k) << 20), 32'h300 + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("full_count", 32'(count_o), 32'd4);
    check("full_ready", 32'(fetch_ready_o), 32'h0);
    for (int k = 0; k < 5; k++)
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("drain_ready", 32'(fetch_ready_o), 32'h1);
    check("drain_n", 32'(dec_log.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check("drain_pc", (k < dec_log.size()) ? dec_log[k] : 32'hDEADDEAD, 32'h300 + 32'(4 * k));

    // Illegal word behind a legal one.
    dec_log.delete();
    step(1'b1, 32'h00000013, 32'h1FC, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000007F, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("trap_flag", 32'(illegal_o), 32'h1);
    check("trap_pc", illegal_pc_o, 32'h200);
    check("trap_instr", illegal_instr_o, 32'h7F);
    step(1'b1, 32'h00000013, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("trap_log", (dec_log.size() == 1) ? dec_log[0] : 32'hDEADDEAD, 32'h1FC);

    // Trap with three entries queued, then flush alongside a push.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h00000033 | (32'(k) << 7), 32'h400 + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("trap3_flag", 32'(illegal_o), 32'h1);
    check("trap3_count", 32'(count_o), 32'd3);
    check("trap3_pc", illegal_pc_o, 32'h400);
    step(1'b1, 32'h00000013, 32'h4AC, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("flush_count", 32'(count_o), 32'h0);
    check("flush_illegal", 32'(illegal_o), 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("flush_dropped", 32'(count_o), 32'h0);

    // Back-to-back push+pop across pointer wrap.
    dec_log.delete();
    step(1'b1, 32'h00000033, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 32'h00000033 | (32'(k) << 7), 32'h600 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check("wrap_count", 32'(count_o), 32'd1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_n", 32'(dec_log.size()), 32'd11);
    for (int k = 0; k < 11; k++)
      check("wrap_pc", (k < dec_log.size()) ? dec_log[k] : 32'hDEADDEAD, 32'h600 + 32'(4 * k));

    // Randomized traffic including flush, reset and validator rejects.
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step($urandom_range(0, 9) < 7, rand_instr(), pc, 1'($urandom_range(0, 1)),
           r < 3, r == 99, $urandom_range(0, 19) == 0);
      pc = pc + 32'd4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
